// File: rtl/sipo_in.sv
// Word-serial to parallel-frame deserializer with a one-frame output buffer (valid/ack).
// Optional sticky OVERRUN flag for dropped words is built when SIPO_OVERRUN_EN is defined.
//
// state | meaning
// ------+----------------------------------------------------------------
// FILL  | accepting words; last word goes straight to DATA_OUT if buffer free
// FULL  | complete frame parked in shift buffer, waiting for LOAD_ACK
module sipo_in #(
  parameter int WIDTH    = 8,
  parameter int NUM_TAPS = 4
) (
  input  logic                      CLKEXT,
  input  logic                      CLR_SIPO_IN_N,
  input  logic                      EN_SIPO_IN,
  input  logic [WIDTH-1:0]          DATA_IN,
  output logic                      IN_READY,
  output logic [WIDTH*NUM_TAPS-1:0] DATA_OUT,
  output logic                      DATA_VALID,
  input  logic                      LOAD_ACK
`ifdef SIPO_OVERRUN_EN
  ,
  output logic                      OVERRUN
`endif
);

  localparam int CW = (NUM_TAPS > 2) ? $clog2(NUM_TAPS) : 1;
  localparam int FW = WIDTH * NUM_TAPS;
  localparam logic [CW-1:0] LAST = CW'(NUM_TAPS - 1);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [FW-1:0]   buf_q, buf_d;
  logic [FW-1:0]   data_out_q, data_out_d;
  logic            data_valid_q, data_valid_d;
  logic            accept;
  logic            buf_free;
  logic            transfer;
  logic [CW-1:0]   lane_idx;

  // Ready is a pure state decode so LOAD_ACK never reaches IN_READY combinationally.
  assign IN_READY   = (state_q == FILL);
  assign DATA_OUT   = data_out_q;
  assign DATA_VALID = data_valid_q;

  assign accept   = EN_SIPO_IN && IN_READY;
  assign buf_free = !data_valid_q || LOAD_ACK;
  assign lane_idx = LAST - cnt_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    transfer     = 1'b0;

    case (state_q)
      FILL: begin
        if (accept) begin
          if (cnt_q != LAST) begin
            buf_d[WIDTH*lane_idx +: WIDTH] = DATA_IN;
            cnt_d = cnt_q + CW'(1);
          end else if (buf_free) begin
            data_out_d   = {buf_q[FW-1:WIDTH], DATA_IN};
            data_valid_d = 1'b1;
            cnt_d        = '0;
            transfer     = 1'b1;
          end else begin
            buf_d[WIDTH-1:0] = DATA_IN;
            state_d          = FULL;
          end
        end
      end
      FULL: begin
        if (LOAD_ACK) begin
          data_out_d   = buf_q;
          data_valid_d = 1'b1;
          cnt_d        = '0;
          state_d      = FILL;
          transfer     = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase

    // An ack that does not coincide with a new frame consumes the current one.
    if (LOAD_ACK && !transfer) begin
      data_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLKEXT or negedge CLR_SIPO_IN_N) begin
    if (!CLR_SIPO_IN_N) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      buf_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

`ifdef SIPO_OVERRUN_EN
  logic overrun_q, overrun_d;

  assign overrun_d = overrun_q || (EN_SIPO_IN && !IN_READY);
  assign OVERRUN   = overrun_q;

  always_ff @(posedge CLKEXT or negedge CLR_SIPO_IN_N) begin
    if (!CLR_SIPO_IN_N) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end
`endif

endmodule
